ptp_gmii_tx: RTL and testbench
==============================

Name: ptp_gmii_tx

Overview:
- Transmit-side counterpart of the GMII snooping time-stamp path.
- Takes 32-bit frame words over a valid/ready stream and serialises them onto GMII (gmii_ctrl/gmii_data). Adds preamble/SFD and enforces a minimum inter-frame gap.
- Emits a start-of-frame strobe aligned with the first preamble byte so the time-stamp logic can capture egress time.
- Sits between the PTP frame builder and the MAC/PHY GMII TX pins.

Parameters:
- IFG_BYTES, 12, minimum number of gmii_clk cycles with gmii_ctrl=0 between frames (legal range 1..255).

Ports:
- gmii_clk  input  1  GMII transmit clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_sop/in_eop/in_mod are valid.
- in_ready  output  1  word is accepted on a cycle where in_valid & in_ready.
- in_data  input  32  frame word; first byte on the wire is [31:24], last is [7:0].
- in_sop  input  1  first word of the frame.
- in_eop  input  1  last word of the frame.
- in_mod  input  2  valid bytes in the eop word: 0 means 4, 1..3 means that count, taken from the top byte down.
- gmii_ctrl  output  1  GMII TX_EN, registered.
- gmii_data  output  8  GMII TXD, registered.
- tx_sop  output  1  one-cycle pulse coincident with the first preamble byte on gmii.
- tx_underrun  output  1  one-cycle pulse when a frame is aborted.
- tx_busy  output  1  high in every state except IDLE.
- tx_frame_cnt  output  16  count of frames completed without error; wraps from 0xFFFF to 0.

Behaviour:
- Reset, asynchronous and taking effect immediately even mid-frame: all outputs are 0, including gmii_ctrl, gmii_data, in_ready and the counters. State returns to IDLE.
- The IFG counter is preloaded to "satisfied", so the first frame after reset can start at once.
- States: IDLE, PRE, DATA, DRAIN, IFG.
- IDLE:
  - in_ready=1.
  - An accepted word with in_sop=1 is latched and the state moves to PRE.
  - An accepted word with in_sop=0 is discarded and the state stays in IDLE.
- PRE:
  - 8 cycles with gmii_ctrl=1: gmii_data=0x55 for cycles 1..7, then 0xD5 on cycle 8.
  - The first PRE cycle appears on gmii the cycle after the sop word is accepted; tx_sop pulses on that same cycle.
  - in_ready=0.
- DATA:
  - gmii_ctrl=1; outputs bytes of the held word in the order [31:24], [23:16], [15:8], [7:0].
  - Number of bytes per word is 4, except an eop word, which outputs in_mod bytes (4 when in_mod=0).
  - in_ready=1 only on the cycle that outputs the final byte of a non-eop word. A word accepted on that cycle supplies the next cycle's byte with no bubble.
  - in_sop seen inside DATA is ignored; the word is treated as ordinary payload.
  - After the final byte of the eop word: tx_frame_cnt increments, and the next cycle has gmii_ctrl=0, gmii_data=0x00 and state IFG.
- Underrun:
  - Occurs when in_ready=1 in DATA and in_valid=0.
  - Next cycle: gmii_ctrl=0, gmii_data=0x00, tx_underrun pulses, state DRAIN. tx_frame_cnt does not increment.
- DRAIN:
  - in_ready=1; words are discarded until a word with in_eop=1 is accepted, then the state moves to IFG.
  - If the underrun-causing word slot was itself pending eop, meaning no further words belong to the frame, the source must still deliver the eop word. No timeout is applied.
- IFG:
  - gmii_ctrl=0, gmii_data=0x00, in_ready=0.
  - The counter starts on the first cycle gmii_ctrl=0 after the frame, with DRAIN cycles counting toward it.
  - Leaves to IDLE once IFG_BYTES idle cycles have elapsed.
  - A sop word may be accepted on the first IDLE cycle, giving exactly IFG_BYTES+1 idle cycles between frames.
- Single-word frame (sop & eop in the same word) is legal and is output as preamble, then in_mod bytes, then IFG.
- A zero-length frame is not representable.
- gmii_data is 0x00 whenever gmii_ctrl=0.

Test Plan:
- Reset release, then accept sop+eop word 0xDEADBEEF with mod=0 -> next cycle tx_sop=1. Sequence on gmii: 55×7, D5, DE, AD, BE, EF (ctrl=1 for 12 cycles), then ctrl=0. tx_frame_cnt=1.
- 3-word frame ending with mod=1, words 0x01020304, 0x05060708, 0x09AABBCC -> bytes 01..08 then 09 only (9 data bytes). in_ready is high exactly on the cycles outputting 04 and 08.
- Two back-to-back frames with in_valid held high -> exactly 13 idle cycles between the last data byte and the next 0x55, using the default IFG_BYTES=12.
- Drop in_valid when the second word is due -> ctrl falls on the next cycle and tx_underrun pulses once. Non-sop words are then absorbed until eop, tx_frame_cnt is unchanged, and the next frame transmits normally.
- Words with in_sop=0 presented in IDLE -> no gmii activity, in_ready=1, and no counter change.
- Assert rst during DATA byte 2 -> gmii_ctrl=0 and gmii_data=0 immediately. The next sop word after release transmits a full preamble.

Source files
------------

// File: rtl/ptp_gmii_tx.sv
// GMII transmit serialiser for the PTP egress path.
// Turns a 32-bit valid/ready frame stream into preamble + SFD + payload bytes
// on GMII, enforces the inter-frame gap and flags the egress start of frame
// so the time-stamp unit can latch the transmit time.
module ptp_gmii_tx #(
    parameter int IFG_BYTES = 12
) (
    input  logic        gmii_clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [1:0]  in_mod,
    output logic        gmii_ctrl,
    output logic [7:0]  gmii_data,
    output logic        tx_sop,
    output logic        tx_underrun,
    output logic        tx_busy,
    output logic [15:0] tx_frame_cnt
);

    localparam logic [7:0] PREAMBLE   = 8'h55;
    localparam logic [7:0] SFD        = 8'hD5;
    localparam logic [7:0] IFG_TARGET = 8'(IFG_BYTES);

    // The state names what gmii is showing in the current cycle; every
    // registered output is computed one edge ahead together with the state.
    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        DRAIN,
        IFG
    } state_t;

    state_t      state;
    logic [2:0]  pre_cnt;
    logic [1:0]  byte_idx;
    logic [31:0] word;
    logic        word_eop;
    logic [1:0]  word_mod;
    logic [7:0]  ifg_cnt;

    logic [1:0]  last_idx;
    logic        last_byte;
    logic [1:0]  next_idx;
    logic [7:0]  ifg_inc;

    // Pick a byte of a word, most significant byte first on the wire.
    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // Index of the final byte of the held word; an eop word may be short
    // and in_mod==0 means a full word.
    always_comb begin
        last_idx = 2'd3;
        if (word_eop && word_mod != 2'd0) begin
            last_idx = word_mod - 2'd1;
        end
    end

    assign last_byte = (byte_idx == last_idx);
    assign next_idx  = byte_idx + 2'd1;
    assign ifg_inc   = (ifg_cnt == 8'hFF) ? ifg_cnt : ifg_cnt + 8'd1;

    // Ready only where a word can be consumed: IDLE, DRAIN, and the last
    // byte of a non-eop word so the next word follows without a bubble.
    // Held low while reset is asserted so the source sees nothing accepted.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                DRAIN:   in_ready = 1'b1;
                DATA:    in_ready = last_byte && !word_eop;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign tx_busy = (state != IDLE);

    // Transmit state machine with registered GMII, strobe and counter outputs.
    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pre_cnt      <= 3'd0;
            byte_idx     <= 2'd0;
            word         <= 32'd0;
            word_eop     <= 1'b0;
            word_mod     <= 2'd0;
            ifg_cnt      <= IFG_TARGET;
            gmii_ctrl    <= 1'b0;
            gmii_data    <= 8'h00;
            tx_sop       <= 1'b0;
            tx_underrun  <= 1'b0;
            tx_frame_cnt <= 16'd0;
        end else begin
            tx_sop      <= 1'b0;
            tx_underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_sop) begin
                        word      <= in_data;
                        word_eop  <= in_eop;
                        word_mod  <= in_mod;
                        pre_cnt   <= 3'd0;
                        gmii_ctrl <= 1'b1;
                        gmii_data <= PREAMBLE;
                        tx_sop    <= 1'b1;
                        state     <= PRE;
                    end else begin
                        gmii_ctrl <= 1'b0;
                        gmii_data <= 8'h00;
                    end
                end
                PRE: begin
                    gmii_ctrl <= 1'b1;
                    if (pre_cnt == 3'd7) begin
                        byte_idx  <= 2'd0;
                        gmii_data <= word[31:24];
                        state     <= DATA;
                    end else begin
                        pre_cnt   <= pre_cnt + 3'd1;
                        gmii_data <= (pre_cnt == 3'd6) ? SFD : PREAMBLE;
                    end
                end
                DATA: begin
                    if (!last_byte) begin
                        byte_idx  <= next_idx;
                        gmii_ctrl <= 1'b1;
                        gmii_data <= sel_byte(word, next_idx);
                    end else if (word_eop) begin
                        tx_frame_cnt <= tx_frame_cnt + 16'd1;
                        gmii_ctrl    <= 1'b0;
                        gmii_data    <= 8'h00;
                        ifg_cnt      <= 8'd1;
                        state        <= IFG;
                    end else if (in_valid) begin
                        word      <= in_data;
                        word_eop  <= in_eop;
                        word_mod  <= in_mod;
                        byte_idx  <= 2'd0;
                        gmii_ctrl <= 1'b1;
                        gmii_data <= in_data[31:24];
                    end else begin
                        tx_underrun <= 1'b1;
                        gmii_ctrl   <= 1'b0;
                        gmii_data   <= 8'h00;
                        ifg_cnt     <= 8'd1;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    gmii_ctrl <= 1'b0;
                    gmii_data <= 8'h00;
                    ifg_cnt   <= ifg_inc;
                    if (in_valid && in_eop) begin
                        state <= IFG;
                    end
                end
                IFG: begin
                    gmii_ctrl <= 1'b0;
                    gmii_data <= 8'h00;
                    if (ifg_cnt >= IFG_TARGET) begin
                        state <= IDLE;
                    end else begin
                        ifg_cnt <= ifg_inc;
                    end
                end
                default: begin
                    gmii_ctrl <= 1'b0;
                    gmii_data <= 8'h00;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ptp_gmii_tx.sv
// Scoreboard bench for ptp_gmii_tx: expected GMII bytes, frame gaps and
// underrun pulses are queued by the stimulus and consumed by a monitor.
module tb_ptp_gmii_tx;

    logic        gmii_clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sop;
    logic        in_eop;
    logic [1:0]  in_mod;
    logic        gmii_ctrl;
    logic [7:0]  gmii_data;
    logic        tx_sop;
    logic        tx_underrun;
    logic        tx_busy;
    logic [15:0] tx_frame_cnt;

    int total = 0;
    int bad = 0;
    int idle_run = 0;
    int und_q = 0;
    int exp_cnt = 0;
    logic [9:0] byte_q[$];
    int frame_q[$];

    ptp_gmii_tx #(.IFG_BYTES(12)) dut (
        .gmii_clk     (gmii_clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .in_mod       (in_mod),
        .gmii_ctrl    (gmii_ctrl),
        .gmii_data    (gmii_data),
        .tx_sop       (tx_sop),
        .tx_underrun  (tx_underrun),
        .tx_busy      (tx_busy),
        .tx_frame_cnt (tx_frame_cnt)
    );

    // Free-running GMII clock.
    initial begin
        gmii_clk = 1'b0;
        forever #5 gmii_clk = ~gmii_clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    // Queue the 8-byte preamble; the first byte carries tx_sop.
    task automatic pushPreamble(input int gap);
        frame_q.push_back(gap);
        byte_q.push_back({1'b0, 1'b1, 8'h55});
        for (int i = 0; i < 6; i++) byte_q.push_back({1'b0, 1'b0, 8'h55});
        byte_q.push_back({1'b0, 1'b0, 8'hD5});
    endtask

    // Queue the bytes of one word; in_ready is expected on the last byte of a non-eop word.
    task automatic pushWord(input logic [31:0] d, input logic eop, input logic [1:0] m);
        int n;
        logic r;
        n = (eop && m != 2'd0) ? int'(m) : 4;
        for (int i = 0; i < n; i++) begin
            r = !eop && (i == n - 1);
            byte_q.push_back({r, 1'b0, d[31 - 8 * i -: 8]});
        end
    endtask

    // Present one word and hold it until accepted; called just after a rising edge.
    task automatic applyStimulus(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m);
        int waited = 0;
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_mod   = m;
        while (!done) begin
            @(negedge gmii_clk);
            if (in_ready) begin
                done = 1;
            end else if (++waited > 400) begin
                failNow("accept_timeout");
                done = 1;
            end
            @(posedge gmii_clk);
            #1;
        end
    endtask

    task automatic dropValid();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    // Wait until the DUT is idle and every queued expectation is consumed.
    task automatic waitQuiet();
        int waited = 0;
        bit done = 0;
        while (!done) begin
            @(negedge gmii_clk);
            if (!tx_busy && byte_q.size() == 0 && und_q == 0) done = 1;
            else if (++waited > 500) begin
                failNow("quiet_timeout");
                done = 1;
            end
        end
        @(posedge gmii_clk);
        #1;
    endtask

    // Monitor: consume expected bytes, gaps and underrun pulses as the DUT shows them.
    always @(negedge gmii_clk) begin
        if (rst) begin
            idle_run = 0;
        end else begin
            if (gmii_ctrl) begin
                if (tx_sop) begin
                    if (frame_q.size() == 0) failNow("unexpected_sop");
                    else begin
                        int g;
                        g = frame_q.pop_front();
                        if (g >= 0) checkOutput("ifg_gap", idle_run, g);
                    end
                end
                if (byte_q.size() == 0) failNow("unexpected_byte");
                else checkOutput("gmii_byte", {22'd0, in_ready, tx_sop, gmii_data}, {22'd0, byte_q.pop_front()});
                idle_run = 0;
            end else begin
                idle_run++;
                checkOutput("idle_quiet", {23'd0, tx_sop, gmii_data}, 32'd0);
            end
            if (tx_underrun) begin
                if (und_q == 0) failNow("unexpected_underrun");
                else und_q--;
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 32'd0;
        in_sop = 1'b0;
        in_eop = 1'b0;
        in_mod = 2'd0;
        #2 rst = 1'b1;
        repeat (3) @(posedge gmii_clk);
        #1;
        checkOutput("reset_gmii", {23'd0, gmii_ctrl, gmii_data}, 32'd0);
        checkOutput("reset_flags", {28'd0, in_ready, tx_sop, tx_underrun, tx_busy}, 32'd0);
        checkOutput("reset_cnt", {16'd0, tx_frame_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge gmii_clk);
        #1;
        checkOutput("idle_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] single-word frame");
        pushPreamble(-1);
        pushWord(32'hDEADBEEF, 1'b1, 2'd0);
        applyStimulus(32'hDEADBEEF, 1'b1, 1'b1, 2'd0);
        dropValid();
        checkOutput("sop_next_cycle", {31'd0, tx_sop}, 32'd1);
        waitQuiet();
        exp_cnt++;
        checkOutput("frame_cnt_1", {16'd0, tx_frame_cnt}, exp_cnt);

        $display("[TB] three-word frame, short tail");
        pushPreamble(-1);
        pushWord(32'h01020304, 1'b0, 2'd0);
        pushWord(32'h05060708, 1'b0, 2'd0);
        pushWord(32'h09AABBCC, 1'b1, 2'd1);
        applyStimulus(32'h01020304, 1'b1, 1'b0, 2'd0);
        applyStimulus(32'h05060708, 1'b0, 1'b0, 2'd0);
        applyStimulus(32'h09AABBCC, 1'b0, 1'b1, 2'd1);
        dropValid();
        waitQuiet();
        exp_cnt++;
        checkOutput("frame_cnt_2", {16'd0, tx_frame_cnt}, exp_cnt);

        $display("[TB] non-sop words in idle");
        applyStimulus(32'h11111111, 1'b0, 1'b0, 2'd0);
        applyStimulus(32'h22222222, 1'b0, 1'b1, 2'd2);
        dropValid();
        repeat (3) @(negedge gmii_clk);
        checkOutput("idle_discard_busy", {31'd0, tx_busy}, 32'd0);
        checkOutput("idle_discard_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("idle_discard_cnt", {16'd0, tx_frame_cnt}, exp_cnt);
        @(posedge gmii_clk);
        #1;

        $display("[TB] back-to-back frames");
        pushPreamble(-1);
        pushWord(32'h11223344, 1'b1, 2'd0);
        pushPreamble(13);
        pushWord(32'hA0B0C0D0, 1'b0, 2'd0);
        pushWord(32'hE0F00000, 1'b1, 2'd2);
        applyStimulus(32'h11223344, 1'b1, 1'b1, 2'd0);
        applyStimulus(32'hA0B0C0D0, 1'b1, 1'b0, 2'd0);
        applyStimulus(32'hE0F00000, 1'b0, 1'b1, 2'd2);
        dropValid();
        waitQuiet();
        exp_cnt += 2;
        checkOutput("frame_cnt_b2b", {16'd0, tx_frame_cnt}, exp_cnt);

        $display("[TB] underrun and drain");
        pushPreamble(-1);
        pushWord(32'h12345678, 1'b0, 2'd0);
        und_q++;
        applyStimulus(32'h12345678, 1'b1, 1'b0, 2'd0);
        dropValid();
        repeat (16) @(posedge gmii_clk);
        #1;
        checkOutput("drain_busy", {31'd0, tx_busy}, 32'd1);
        applyStimulus(32'hFFFFFFFF, 1'b0, 1'b0, 2'd0);
        applyStimulus(32'hEEEEEEEE, 1'b0, 1'b1, 2'd3);
        dropValid();
        waitQuiet();
        checkOutput("underrun_cnt", {16'd0, tx_frame_cnt}, exp_cnt);
        pushPreamble(-1);
        pushWord(32'h0A0B0C0D, 1'b1, 2'd3);
        applyStimulus(32'h0A0B0C0D, 1'b1, 1'b1, 2'd3);
        dropValid();
        waitQuiet();
        exp_cnt++;
        checkOutput("recover_cnt", {16'd0, tx_frame_cnt}, exp_cnt);

        $display("[TB] reset mid-frame");
        pushPreamble(-1);
        byte_q.push_back({1'b0, 1'b0, 8'hCA});
        byte_q.push_back({1'b0, 1'b0, 8'hFE});
        applyStimulus(32'hCAFEF00D, 1'b1, 1'b0, 2'd0);
        dropValid();
        repeat (9) @(posedge gmii_clk);
        @(negedge gmii_clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_async_gmii", {23'd0, gmii_ctrl, gmii_data}, 32'd0);
        checkOutput("rst_async_cnt", {16'd0, tx_frame_cnt}, 32'd0);
        repeat (2) @(posedge gmii_clk);
        #1 rst = 1'b0;
        exp_cnt = 0;
        @(posedge gmii_clk);
        #1;
        pushPreamble(-1);
        pushWord(32'h13579BDF, 1'b1, 2'd0);
        applyStimulus(32'h13579BDF, 1'b1, 1'b1, 2'd0);
        dropValid();
        waitQuiet();
        exp_cnt++;
        checkOutput("post_reset_cnt", {16'd0, tx_frame_cnt}, exp_cnt);

        checkOutput("bytes_left", byte_q.size(), 32'd0);
        checkOutput("frames_left", frame_q.size(), 32'd0);
        checkOutput("underruns_left", und_q, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
